// File: rtl/mem_io_arbiter.sv
// Bridges the mem mesh io ports to one shared word bus: round-robin outbound serialiser, inbound pulse replay.
// Optional build macro MEM_IO_LOOPBACK_EN adds lb_en, which replays granted slots back into the mesh.
module mem_io_arbiter #(
    parameter int PORTS = 4,
    parameter int DW    = 8,
    parameter int PW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef MEM_IO_LOOPBACK_EN
    input  logic                lb_en,
`endif
    input  logic [PORTS-1:0]    mesh_act_out,
    input  logic [PORTS*DW-1:0] mesh_dat_out,
    output logic [PORTS-1:0]    mesh_act_in,
    output logic [PORTS*DW-1:0] mesh_dat_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PW-1:0]       out_port,
    output logic [DW-1:0]       out_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PW-1:0]       in_port,
    input  logic [DW-1:0]       in_data,
    output logic [PORTS-1:0]    ovf,
    output logic                perr
);

    logic lb;
`ifdef MEM_IO_LOOPBACK_EN
    assign lb = lb_en;
`else
    assign lb = 1'b0;
`endif

    logic [PORTS-1:0] slot_vld_p0;
    logic [DW-1:0]    slot_dat_p0 [PORTS];
    logic [PW-1:0]    rr;
    logic [PW:0]      pick;
    logic             any_vld;
    logic [PW-1:0]    grant;
    logic [DW-1:0]    grant_dat;
    logic [PORTS-1:0] grant_sel;
    logic             out_free;
    logic             take;
    logic [PORTS-1:0]    nxt_act;
    logic [PORTS*DW-1:0] nxt_dat;
    logic                perr_hit;

    // Returns {found, index} of the first valid slot at or after start, wrapping at PORTS.
    function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] v, input logic [PW-1:0] start);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = 0; i < PORTS; i++) begin
            idx = int'(start) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!res[PW] && v[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] g);
        return (int'(g) == PORTS - 1) ? '0 : g + 1'b1;
    endfunction

    assign pick     = rr_pick(slot_vld_p0, rr);
    assign any_vld  = pick[PW];
    assign grant    = pick[PW-1:0];
    assign out_free = !out_valid || out_ready;
    assign take     = any_vld && (lb || out_free);
    assign in_ready = rst_n && !lb;

    always_comb begin
        grant_dat = '0;
        grant_sel = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (int'(grant) == p) begin
                grant_dat    = slot_dat_p0[p];
                grant_sel[p] = take;
            end
        end
    end

    // Stage 0: capture mesh pulses into pending slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld_p0 <= '0;
            ovf         <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (grant_sel[p]) slot_vld_p0[p] <= 1'b0;
                if (mesh_act_out[p]) begin
                    slot_vld_p0[p] <= 1'b1;
                    if (slot_vld_p0[p] && !grant_sel[p]) ovf[p] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (mesh_act_out[p]) slot_dat_p0[p] <= mesh_dat_out[p*DW +: DW];
        end
    end

    // Stage 1: outbound word register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_port  <= '0;
            out_data  <= '0;
            rr        <= '0;
        end else begin
            if (take) begin
                rr <= wrap_inc(grant);
                if (!lb) begin
                    out_valid <= 1'b1;
                    out_port  <= grant;
                    out_data  <= grant_dat;
                end
            end
            if (lb || (out_free && !any_vld)) out_valid <= 1'b0;
        end
    end

    // Inbound words (or loopback replays) become a single-cycle mesh write
    always_comb begin
        nxt_act  = '0;
        nxt_dat  = '0;
        perr_hit = 1'b0;
        if (lb) begin
            for (int p = 0; p < PORTS; p++) begin
                if (grant_sel[p]) begin
                    nxt_act[p]          = 1'b1;
                    nxt_dat[p*DW +: DW] = grant_dat;
                end
            end
        end else if (in_valid && in_ready) begin
            if (int'(in_port) >= PORTS) perr_hit = 1'b1;
            for (int p = 0; p < PORTS; p++) begin
                if (int'(in_port) == p) begin
                    nxt_act[p]          = 1'b1;
                    nxt_dat[p*DW +: DW] = in_data;
                end
            end
        end
    end

    // Stage 1: mesh write register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mesh_act_in <= '0;
            mesh_dat_in <= '0;
            perr        <= 1'b0;
        end else begin
            mesh_act_in <= nxt_act;
            mesh_dat_in <= nxt_dat;
            if (perr_hit) perr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Randomized bench for mem_io_arbiter (PORTS=4, DW=8) against a queue/array reference model.
module tb_mem_io_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int PW    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                lb_v;
    logic [PORTS-1:0]    mesh_act_out;
    logic [PORTS*DW-1:0] mesh_dat_out;
    logic [PORTS-1:0]    mesh_act_in;
    logic [PORTS*DW-1:0] mesh_dat_in;
    logic                out_valid;
    logic                out_ready;
    logic [PW-1:0]       out_port;
    logic [DW-1:0]       out_data;
    logic                in_valid;
    logic                in_ready;
    logic [PW-1:0]       in_port;
    logic [DW-1:0]       in_data;
    logic [PORTS-1:0]    ovf;
    logic                perr;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state
    bit          m_pv [PORTS];
    logic [7:0]  m_pd [PORTS];
    bit          m_ov;
    int          m_op;
    logic [7:0]  m_od;
    int          m_rr;
    logic [3:0]  m_act;
    logic [31:0] m_dat;
    logic [3:0]  m_ovf;
    bit          m_perr;

    always #5 clk = ~clk;

    mem_io_arbiter #(.PORTS(PORTS), .DW(DW), .PW(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MEM_IO_LOOPBACK_EN
        .lb_en        (lb_v),
`endif
        .mesh_act_out (mesh_act_out),
        .mesh_dat_out (mesh_dat_out),
        .mesh_act_in  (mesh_act_in),
        .mesh_dat_in  (mesh_dat_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_port     (out_port),
        .out_data     (out_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_port      (in_port),
        .in_data      (in_data),
        .ovf          (ovf),
        .perr         (perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        if (m_ov) begin
            check("out_port", {29'b0, out_port}, m_op);
            check("out_data", {24'b0, out_data}, {24'b0, m_od});
        end
        check("mesh_act_in", {28'b0, mesh_act_in}, {28'b0, m_act});
        check("mesh_dat_in", mesh_dat_in, m_dat);
        check("ovf", {28'b0, ovf}, {28'b0, m_ovf});
        check("perr", {31'b0, perr}, {31'b0, m_perr});
        check("in_ready", {31'b0, in_ready}, {31'b0, (rst_n && !lb_v)});
    endtask

    // One clock: apply the rules to the inputs seen at the edge, then compare just after it.
    task automatic tick();
        bit   found, free, take;
        int   g;
        @(posedge clk);
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) m_pv[p] = 0;
            m_ov = 0; m_op = 0; m_od = 0; m_rr = 0;
            m_act = 0; m_dat = 0; m_ovf = 0; m_perr = 0;
        end else begin
            found = 0; g = 0;
            for (int i = 0; i < PORTS; i++) begin
                if (!found && m_pv[(m_rr + i) % PORTS]) begin
                    found = 1;
                    g = (m_rr + i) % PORTS;
                end
            end
            free  = !m_ov || out_ready;
            take  = found && (lb_v || free);
            m_act = 0;
            m_dat = 0;
            if (lb_v) begin
                if (take) begin
                    m_act[g] = 1'b1;
                    m_dat[g*8 +: 8] = m_pd[g];
                end
            end else if (in_valid) begin
                if (int'(in_port) < PORTS) begin
                    m_act[in_port] = 1'b1;
                    m_dat[int'(in_port)*8 +: 8] = in_data;
                end else begin
                    m_perr = 1;
                end
            end
            if (lb_v) m_ov = 0;
            else if (take) begin m_ov = 1; m_op = g; m_od = m_pd[g]; end
            else if (free) m_ov = 0;
            if (take) begin
                m_pv[g] = 0;
                m_rr = (g + 1) % PORTS;
            end
            for (int p = 0; p < PORTS; p++) begin
                if (mesh_act_out[p]) begin
                    if (m_pv[p]) m_ovf[p] = 1'b1;
                    m_pv[p] = 1;
                    m_pd[p] = mesh_dat_out[p*8 +: 8];
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; lb_v = 1'b0;
        mesh_act_out = '0; mesh_dat_out = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_port = '0; in_data = '0;
        tick(); tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_port", {29'b0, out_port}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_mesh_act", {28'b0, mesh_act_in}, 32'd0);
        check("rst_mesh_dat", mesh_dat_in, 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Two ports pulse together, out_ready high
        out_ready = 1'b1;
        mesh_act_out = 4'b0101; mesh_dat_out = 32'h0033_0011;
        tick(); mesh_act_out = '0;
        tick();
        check("t1_c2_valid", {31'b0, out_valid}, 32'd1);
        check("t1_c2_port", {29'b0, out_port}, 32'd0);
        check("t1_c2_data", {24'b0, out_data}, 32'h11);
        tick();
        check("t1_c3_port", {29'b0, out_port}, 32'd2);
        check("t1_c3_data", {24'b0, out_data}, 32'h33);
        tick();
        check("t1_c4_valid", {31'b0, out_valid}, 32'd0);

        // All ports pending from rr=0
        do_reset();
        out_ready = 1'b0;
        mesh_act_out = 4'hF; mesh_dat_out = 32'hB3B2_B1B0;
        tick(); mesh_act_out = '0;
        tick();
        check("rr0_first", {29'b0, out_port}, 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("rr0_order", {29'b0, out_port}, k);
            check("rr0_data", {24'b0, out_data}, 32'hB0 + k);
        end
        tick();
        check("rr0_drain", {31'b0, out_valid}, 32'd0);

        // Move rr to 2 with a single port-1 word, then all ports again
        mesh_act_out = 4'b0010; mesh_dat_out = 32'h0000_4400;
        tick(); mesh_act_out = '0;
        tick(); tick();
        out_ready = 1'b0;
        mesh_act_out = 4'hF; mesh_dat_out = 32'hC3C2_C1C0;
        tick(); mesh_act_out = '0;
        tick();
        check("rr2_first", {29'b0, out_port}, 32'd2);
        out_ready = 1'b1;
        tick(); check("rr2_second", {29'b0, out_port}, 32'd3);
        tick(); check("rr2_third", {29'b0, out_port}, 32'd0);
        tick(); check("rr2_fourth", {29'b0, out_port}, 32'd1);
        tick(); check("rr2_drain", {31'b0, out_valid}, 32'd0);

        // Overwrite while the output register is busy
        do_reset();
        out_ready = 1'b0;
        mesh_act_out = 4'b0001; mesh_dat_out = 32'h0000_000F;
        tick();
        mesh_act_out = 4'b0010; mesh_dat_out = 32'h0000_A000;
        tick(); mesh_act_out = '0;
        tick();
        mesh_act_out = 4'b0010; mesh_dat_out = 32'h0000_A100;
        tick(); mesh_act_out = '0;
        tick();
        check("ovf_set", {28'b0, ovf}, 32'h2);
        check("ovf_hold_port", {29'b0, out_port}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("ovf_last_port", {29'b0, out_port}, 32'd1);
        check("ovf_last_data", {24'b0, out_data}, 32'hA1);
        tick();
        check("ovf_drain", {31'b0, out_valid}, 32'd0);

        // Inbound replay and out-of-range port
        in_valid = 1'b1; in_port = 3'd3; in_data = 8'h5C;
        tick(); in_valid = 1'b0;
        check("in_act", {28'b0, mesh_act_in}, 32'h8);
        check("in_dat", {24'b0, mesh_dat_in[31:24]}, 32'h5C);
        check("in_other_dat", {8'b0, mesh_dat_in[23:0]}, 32'd0);
        tick();
        check("in_act_one_cycle", {28'b0, mesh_act_in}, 32'd0);
        in_valid = 1'b1; in_port = 3'd5; in_data = 8'h99;
        tick(); in_valid = 1'b0;
        check("perr_act", {28'b0, mesh_act_in}, 32'd0);
        check("perr_set", {31'b0, perr}, 32'd1);

`ifdef MEM_IO_LOOPBACK_EN
        do_reset();
        lb_v = 1'b1;
        mesh_act_out = 4'b0100; mesh_dat_out = 32'h007E_0000;
        tick(); mesh_act_out = '0;
        tick();
        check("lb_act", {28'b0, mesh_act_in}, 32'h4);
        check("lb_dat", {24'b0, mesh_dat_in[23:16]}, 32'h7E);
        check("lb_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        lb_v = 1'b0;
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 249) != 0);
            mesh_act_out = 4'($urandom) & 4'($urandom);
            mesh_dat_out = $urandom;
            out_ready    = ($urandom_range(0, 3) != 0);
            in_valid     = $urandom_range(0, 1) == 1;
            in_port      = 3'($urandom_range(0, 7));
            in_data      = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
